// File: rtl/riscv_formal_pc_order_checker.sv
// RVFI retirement-stream checker: verifies PC continuity, rvfi_order sequencing,
// channel contiguity and (optionally) halt-after-trap, latching the first error.

module riscv_formal_pc_order_lane #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic               valid,
    input  logic               prev_valid,
    input  logic               chk_ref,
    input  logic               halted,
    input  logic               trap_below,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    ref_pc,
    input  logic [ORDER_W-1:0] order,
    input  logic [ORDER_W-1:0] ref_order,
    output logic [2:0]         code
);
    // Priority chain yields the lowest applicable code for this channel.
    always_comb begin
        code = 3'd0;
        if (valid) begin
            if (!prev_valid)
                code = 3'd1;
            else if (chk_ref && (pc != ref_pc))
                code = 3'd2;
            else if (chk_ref && (order != ref_order))
                code = 3'd3;
            else if (halted || trap_below)
                code = 3'd4;
        end
    end
endmodule

module riscv_formal_pc_order_checker #(
    parameter int XLEN      = 32,
    parameter int NRET      = 1,
    parameter int ORDER_W   = 64,
    parameter int CNT_W     = 32,
    parameter int TRAP_HALT = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NRET-1:0]           rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]   rvfi_order,
    input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
    input  logic [NRET-1:0]           rvfi_trap,
    output logic                      err,
    output logic [2:0]                err_code,
    output logic [7:0]                err_chan,
    output logic [CNT_W-1:0]          retired_cnt,
    output logic [XLEN-1:0]           expect_pc
);
    typedef enum logic [1:0] {WAIT_FIRST, TRACK, HALTED, FAIL} state_t;

    localparam logic [CNT_W+7:0] CNT_MAX = {8'd0, {CNT_W{1'b1}}};

    state_t               state;
    logic [ORDER_W-1:0]   next_order;

    logic [NRET-1:0][XLEN-1:0]    pc_r, pc_w;
    logic [NRET-1:0][ORDER_W-1:0] ord;

    assign pc_r = rvfi_pc_rdata;
    assign pc_w = rvfi_pc_wdata;
    assign ord  = rvfi_order;

    logic [NRET-1:0]              prev_v, chk_ref, trap_below;
    logic [NRET-1:0][XLEN-1:0]    ref_pc;
    logic [NRET-1:0][ORDER_W-1:0] ref_ord;
    logic [NRET-1:0][2:0]         lane_code;

    // Channel 0 compares against stored state; higher channels chain off
    // their lower neighbour in the same cycle.
    always_comb begin
        prev_v        = '1;
        chk_ref       = '1;
        trap_below    = '0;
        ref_pc        = '0;
        ref_ord       = '0;
        ref_pc[0]     = expect_pc;
        ref_ord[0]    = next_order;
        chk_ref[0]    = (state == TRACK);
        for (int k = 1; k < NRET; k++) begin
            prev_v[k]     = rvfi_valid[k-1];
            ref_pc[k]     = pc_w[k-1];
            ref_ord[k]    = ord[k-1] + 1'b1;
            trap_below[k] = trap_below[k-1] | (rvfi_valid[k-1] & rvfi_trap[k-1]);
        end
        if (TRAP_HALT == 0)
            trap_below = '0;
    end

    for (genvar g = 0; g < NRET; g++) begin : g_lane
        riscv_formal_pc_order_lane #(
            .XLEN    (XLEN),
            .ORDER_W (ORDER_W)
        ) u_lane (
            .valid      (rvfi_valid[g]),
            .prev_valid (prev_v[g]),
            .chk_ref    (chk_ref[g]),
            .halted     (state == HALTED),
            .trap_below (trap_below[g]),
            .pc         (pc_r[g]),
            .ref_pc     (ref_pc[g]),
            .order      (ord[g]),
            .ref_order  (ref_ord[g]),
            .code       (lane_code[g])
        );
    end

    logic                any_err, any_trap;
    logic [2:0]          sel_code;
    logic [7:0]          sel_chan, nval;
    logic [XLEN-1:0]     nxt_pc;
    logic [ORDER_W-1:0]  nxt_ord;
    logic [CNT_W+7:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_nxt;

    // Lowest erroring channel wins; highest valid channel sets the next reference.
    always_comb begin
        any_err  = 1'b0;
        sel_code = 3'd0;
        sel_chan = 8'd0;
        for (int k = NRET - 1; k >= 0; k--) begin
            if (lane_code[k] != 3'd0) begin
                any_err  = 1'b1;
                sel_code = lane_code[k];
                sel_chan = 8'(k);
            end
        end
        nval     = 8'd0;
        nxt_pc   = expect_pc;
        nxt_ord  = next_order;
        any_trap = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k]) begin
                nval     = nval + 8'd1;
                nxt_pc   = pc_w[k];
                nxt_ord  = ord[k] + 1'b1;
                any_trap = any_trap | rvfi_trap[k];
            end
        end
        if (TRAP_HALT == 0)
            any_trap = 1'b0;
        cnt_sum = {8'd0, retired_cnt} + {{CNT_W{1'b0}}, nval};
        cnt_nxt = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= WAIT_FIRST;
            err         <= 1'b0;
            err_code    <= 3'd0;
            err_chan    <= 8'd0;
            retired_cnt <= '0;
            expect_pc   <= '0;
            next_order  <= '0;
        end else if (state != FAIL && rvfi_valid != '0) begin
            if (any_err) begin
                state    <= FAIL;
                err      <= 1'b1;
                err_code <= sel_code;
                err_chan <= sel_chan;
            end else begin
                state       <= any_trap ? HALTED : TRACK;
                retired_cnt <= cnt_nxt;
                expect_pc   <= nxt_pc;
                next_order  <= nxt_ord;
            end
        end
    end
endmodule

// File: tb/tb_riscv_formal_pc_order_checker.sv
// Two checkers (TRAP_HALT=1 and 0, NRET=2, ORDER_W=4, CNT_W=4) fed the same
// stream; directed cases then random traffic against a rule-level model.

module tb_riscv_formal_pc_order_checker;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [1:0]        valid = '0, trap = '0;
    logic [1:0][31:0]  pcr = '0, pcw = '0;
    logic [1:0][3:0]   ord = '0;

    logic [1:0]        err;
    logic [1:0][2:0]   code;
    logic [1:0][7:0]   chan;
    logic [1:0][3:0]   cnt;
    logic [1:0][31:0]  epc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        riscv_formal_pc_order_checker #(
            .XLEN(32), .NRET(2), .ORDER_W(4), .CNT_W(4), .TRAP_HALT(i == 0 ? 1 : 0)
        ) dut (
            .clk           (clk),
            .resetn        (resetn),
            .rvfi_valid    (valid),
            .rvfi_order    (ord),
            .rvfi_pc_rdata (pcr),
            .rvfi_pc_wdata (pcw),
            .rvfi_trap     (trap),
            .err           (err[i]),
            .err_code      (code[i]),
            .err_chan      (chan[i]),
            .retired_cnt   (cnt[i]),
            .expect_pc     (epc[i])
        );
    end

    // Reference model: index 0 halts on trap, index 1 ignores traps.
    bit        m_started[2], m_halted[2], m_fail[2];
    int        m_code[2], m_chan[2], m_cnt[2];
    logic [31:0] m_pc[2];
    logic [3:0]  m_ord[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_started[i] = 0; m_halted[i] = 0; m_fail[i] = 0;
            m_code[i] = 0; m_chan[i] = 0; m_cnt[i] = 0;
            m_pc[i] = '0; m_ord[i] = '0;
        end
    endtask

    // First rule violated in order gap, pc, order, trap.
    function automatic int rule_code(bit gap, bit pc_bad, bit ord_bad, bit trap_bad);
        if (gap) return 1;
        if (pc_bad) return 2;
        if (ord_bad) return 3;
        if (trap_bad) return 4;
        return 0;
    endfunction

    task automatic model_step(input int i);
        bit th = (i == 0);
        bit tracked;
        int c0, c1, hi;
        logic [3:0] o1ref;
        if (m_fail[i] || valid == 2'b00) return;
        tracked = m_started[i] && !m_halted[i];
        o1ref = ord[0] + 4'd1;
        c0 = valid[0] ? rule_code(0, tracked && pcr[0] != m_pc[i],
                                  tracked && ord[0] != m_ord[i], m_halted[i]) : 0;
        c1 = valid[1] ? rule_code(!valid[0], pcr[1] != pcw[0], ord[1] != o1ref,
                                  m_halted[i] || (th && valid[0] && trap[0])) : 0;
        if (c0 != 0 || c1 != 0) begin
            m_fail[i] = 1;
            m_code[i] = (c0 != 0) ? c0 : c1;
            m_chan[i] = (c0 != 0) ? 0 : 1;
        end else begin
            m_cnt[i] = m_cnt[i] + int'(valid[0]) + int'(valid[1]);
            if (m_cnt[i] > 15) m_cnt[i] = 15;
            hi = valid[1] ? 1 : 0;
            m_pc[i] = pcw[hi];
            m_ord[i] = ord[hi] + 4'd1;
            m_started[i] = 1;
            m_halted[i] = th && ((valid & trap) != 2'b00);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s.err%0d", tag, i),  {31'd0, err[i]},  {31'd0, m_fail[i]});
            chk($sformatf("%s.code%0d", tag, i), {29'd0, code[i]}, m_code[i]);
            chk($sformatf("%s.chan%0d", tag, i), {24'd0, chan[i]}, m_chan[i]);
            chk($sformatf("%s.cnt%0d", tag, i),  {28'd0, cnt[i]},  m_cnt[i]);
            chk($sformatf("%s.epc%0d", tag, i),  epc[i],           m_pc[i]);
        end
    endtask

    // Inputs are applied before the next rising edge, checked 1ns after it.
    task automatic step(input string tag, input logic [1:0] v, input logic [1:0] t,
                        input logic [31:0] r0, input logic [31:0] w0, input logic [3:0] o0,
                        input logic [31:0] r1, input logic [31:0] w1, input logic [3:0] o1);
        valid = v; trap = t;
        pcr[0] = r0; pcw[0] = w0; ord[0] = o0;
        pcr[1] = r1; pcw[1] = w1; ord[1] = o1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1 check_all(tag);
    endtask

    // Reset pulse placed entirely between two rising edges.
    task automatic pulse_reset(input string tag);
        valid = '0; trap = '0;
        #2 resetn = 1'b0;
        #1 model_reset();
        check_all(tag);
        #1 resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc, wpc, r1;
        logic [3:0]  ro, o1;
        logic [1:0]  v, t;
        int r;
        model_reset();
        #2 check_all("por");
        #1 resetn = 1'b1;

        step("two_wide", 2'b11, 2'b00, 32'h100, 32'h104, 4'd5, 32'h104, 32'h108, 4'd6);
        step("one_wide", 2'b01, 2'b00, 32'h108, 32'h10C, 4'd7, 32'h0, 32'h0, 4'd0);
        chk("seq_cnt", {28'd0, cnt[1]}, 32'd3);
        chk("seq_epc", epc[1], 32'h10C);
        step("gap", 2'b10, 2'b00, 32'h0, 32'h0, 4'd0, 32'h10C, 32'h110, 4'd8);
        chk("gap_code", {29'd0, code[1]}, 32'd1);
        chk("gap_chan", {24'd0, chan[1]}, 32'd1);
        step("gap_frozen", 2'b01, 2'b00, 32'h10C, 32'h110, 4'd8, 32'h0, 32'h0, 4'd0);
        pulse_reset("rst_fail");

        step("seed200", 2'b01, 2'b00, 32'h1FC, 32'h200, 4'd0, 32'h0, 32'h0, 4'd0);
        step("pc_bad", 2'b01, 2'b00, 32'h204, 32'h208, 4'd1, 32'h0, 32'h0, 4'd0);
        chk("pc_code", {29'd0, code[0]}, 32'd2);
        step("pc_frozen", 2'b01, 2'b00, 32'h200, 32'h204, 4'd1, 32'h0, 32'h0, 4'd0);
        chk("pc_epc", epc[0], 32'h200);
        pulse_reset("rst_pc");

        step("wrap14", 2'b01, 2'b00, 32'h300, 32'h304, 4'd14, 32'h0, 32'h0, 4'd0);
        step("wrap15", 2'b01, 2'b00, 32'h304, 32'h308, 4'd15, 32'h0, 32'h0, 4'd0);
        step("wrap0",  2'b01, 2'b00, 32'h308, 32'h30C, 4'd0,  32'h0, 32'h0, 4'd0);
        chk("wrap_err", {31'd0, err[1]}, 32'd0);
        chk("wrap_cnt", {28'd0, cnt[1]}, 32'd3);
        step("ord_bad", 2'b01, 2'b00, 32'h30C, 32'h310, 4'd2, 32'h0, 32'h0, 4'd0);
        pulse_reset("rst_ord");

        step("trap", 2'b01, 2'b01, 32'h40, 32'h44, 4'd1, 32'h0, 32'h0, 4'd0);
        step("after_trap", 2'b01, 2'b00, 32'h44, 32'h48, 4'd2, 32'h0, 32'h0, 4'd0);
        chk("trap_code1", {29'd0, code[0]}, 32'd4);
        chk("trap_err0", {31'd0, err[1]}, 32'd0);
        pulse_reset("rst_trap");
        step("trap_same", 2'b11, 2'b01, 32'h50, 32'h54, 4'd3, 32'h54, 32'h58, 4'd4);
        pulse_reset("rst_trap2");

        for (int n = 0; n < 9; n++)
            step("sat", 2'b11, 2'b00, 32'h800 + 8 * n, 32'h804 + 8 * n, 4'(2 * n),
                 32'h804 + 8 * n, 32'h808 + 8 * n, 4'(2 * n + 1));
        chk("sat_cnt", {28'd0, cnt[1]}, 32'd15);
        step("idle", 2'b00, 2'b11, 32'hDEAD, 32'hBEEF, 4'd9, 32'h1, 32'h2, 4'd3);
        pulse_reset("rst_sat");

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 15));
            v = (r < 3) ? 2'b00 : (r == 3) ? 2'b10 : (r < 10) ? 2'b01 : 2'b11;
            t = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            rpc = m_pc[1];
            if ($urandom_range(0, 11) == 0) rpc = rpc + 32'd4;
            wpc = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'd3) : rpc + 32'd4;
            ro = m_ord[1];
            if ($urandom_range(0, 15) == 0) ro = ro + 4'd3;
            r1 = ($urandom_range(0, 15) == 0) ? wpc + 32'd8 : wpc;
            o1 = ($urandom_range(0, 15) == 0) ? ro : ro + 4'd1;
            step("rand", v, t, rpc, wpc, ro, r1, r1 + 32'd4, o1);
            if ((m_fail[1] && $urandom_range(0, 3) == 0) || (m_fail[0] && $urandom_range(0, 9) == 0))
                pulse_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_formal_pc_order_checker.md
RISCV_FORMAL_PC_ORDER_CHECKER -- requirements
Module: riscv_formal_pc_order_checker

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk, resetn.
REQ-002 Parameter XLEN, default 32, SHALL set the PC width.
REQ-003 Parameter NRET, default 1, SHALL set the number of retirement channels.
REQ-004 Parameter ORDER_W, default 64, SHALL set the rvfi_order width per channel.
REQ-005 Parameter CNT_W, default 32, SHALL set the retired-instruction counter width.
REQ-006 Parameter TRAP_HALT, default 0, SHALL, when 1, make any retirement after a trap an error.
REQ-007 clk  input  1  sampling clock, all state on rising edge.
REQ-008 resetn  input  1  asynchronous active-low reset.
REQ-009 rvfi_valid  input  NRET  per-channel retirement strobe.
REQ-010 rvfi_order  input  NRET*ORDER_W  per-channel instruction index, channel k at [k*ORDER_W +: ORDER_W].
REQ-011 rvfi_pc_rdata  input  NRET*XLEN  PC of the retired instruction.
REQ-012 rvfi_pc_wdata  input  NRET*XLEN  next PC after the retired instruction.
REQ-013 rvfi_trap  input  NRET  retired instruction trapped.
REQ-014 err  output  1  sticky error flag.
REQ-015 err_code  output  3  first error cause: 0 none, 1 channel gap, 2 PC mismatch, 3 order mismatch, 4 retire after trap.
REQ-016 err_chan  output  8  channel index of the first error.
REQ-017 retired_cnt  output  CNT_W  saturating count of checked retirements.
REQ-018 expect_pc  output  XLEN  PC required of the next retirement.

Function
REQ-019 States SHALL be WAIT_FIRST, TRACK, HALTED, FAIL.
REQ-020 A cycle's valid channels SHALL be contiguous from channel 0; valid[k] with !valid[k-1] is a gap error on channel k.
REQ-021 In WAIT_FIRST, the first cycle with any valid SHALL seed the reference from channel 0 (PC and order not checked against stored state) and go to TRACK.
REQ-022 In TRACK, channel 0 pc_rdata SHALL equal expect_pc and order SHALL equal the stored next order.
REQ-023 Within a cycle, valid channel k>0 SHALL have pc_rdata equal to channel k-1 pc_wdata and order equal to channel k-1 order + 1.
REQ-024 Order arithmetic SHALL be modulo 2^ORDER_W; the wrap from all-ones to 0 is legal.
REQ-025 After a cycle with valid channels, expect_pc SHALL become pc_wdata and next order SHALL become order+1 of the highest valid channel.
REQ-026 When TRAP_HALT=1 and a valid channel has rvfi_trap=1, any higher valid channel in the same cycle is error 4, else state goes to HALTED; any valid in HALTED is error 4 on that channel.
REQ-027 When TRAP_HALT=0, rvfi_trap SHALL not affect checking.
REQ-028 Multiple errors in one cycle SHALL report the lowest channel; per channel, the lowest code wins.
REQ-029 err, err_code, err_chan SHALL be registered, asserting the cycle after the offending sample, and state SHALL go to FAIL.
REQ-030 FAIL SHALL be terminal until reset: err/err_code/err_chan/expect_pc/retired_cnt frozen, inputs ignored.
REQ-031 retired_cnt SHALL add the number of valid channels of each error-free cycle and saturate at 2^CNT_W-1.
REQ-032 A cycle with no valid channels SHALL change no state.

Reset
REQ-033 resetn low SHALL immediately set state WAIT_FIRST, err 0, err_code 0, err_chan 0, retired_cnt 0, expect_pc 0, next order 0, including mid-operation or in FAIL.
REQ-034 The first rising clk edge after resetn deasserts SHALL sample normally.

Verification
REQ-035 NRET=2: cycle 1 ch0 pc 0x100->0x104 order 5, ch1 0x104->0x108 order 6; cycle 2 ch0 pc 0x108 order 7 -> err 0, retired_cnt 3, expect_pc 0x10C.
REQ-036 NRET=2: valid=2'b10 -> next cycle err 1, err_code 1, err_chan 1, retired_cnt unchanged.
REQ-037 NRET=1: expect_pc 0x200, retire pc 0x204 -> err_code 2, err_chan 0; later legal retirements leave outputs frozen.
REQ-038 ORDER_W=4: orders 14, 15, 0 in consecutive cycles with matching PCs -> err 0, retired_cnt 3.
REQ-039 TRAP_HALT=1, NRET=1: retire with trap=1, then any valid -> err_code 4; same stimulus with TRAP_HALT=0 -> err 0.
REQ-040 In FAIL, pulse resetn low between edges -> outputs 0 immediately, state WAIT_FIRST, next retirement seeds without error.
